// File: rtl/corner_filter.sv
// corner_filter: snapshots the four detector corners on each VGA_VS fall, validates the
// quad, IIR-smooths every coordinate and tracks lock/loss. Option macro: CORNER_JUMP_RESEED_EN.
module corner_filter #(
   parameter int SHIFT       = 2,
   parameter int MIN_SPAN    = 16,
   parameter int LOCK_FRAMES = 4,
   parameter int MISS_FRAMES = 8,
   parameter int JUMP_THRESH = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       VGA_VS,
   input  logic [9:0] top_left_x_in,
   input  logic [9:0] top_left_y_in,
   input  logic [9:0] top_right_x_in,
   input  logic [9:0] top_right_y_in,
   input  logic [9:0] bot_left_x_in,
   input  logic [9:0] bot_left_y_in,
   input  logic [9:0] bot_right_x_in,
   input  logic [9:0] bot_right_y_in,
   output logic [9:0] tl_x,
   output logic [9:0] tl_y,
   output logic [9:0] tr_x,
   output logic [9:0] tr_y,
   output logic [9:0] bl_x,
   output logic [9:0] bl_y,
   output logic [9:0] br_x,
   output logic [9:0] br_y,
   output logic       frame_done,
   output logic       frame_valid,
   output logic       locked
);

   localparam logic signed [10:0] MIN_SPAN_S = 11'(MIN_SPAN);
   localparam logic signed [10:0] JUMP_S     = 11'(JUMP_THRESH);
   localparam logic [3:0]         LOCK_N     = 4'(LOCK_FRAMES);
   localparam logic [3:0]         MISS_N     = 4'(MISS_FRAMES);
`ifdef CORNER_JUMP_RESEED_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CHECK, S_FILTER, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic            vs_prev_q;
   logic            frame_ok_q, frame_ok_d;
   logic            seeded_q, seeded_d;
   logic [3:0]      valid_cnt_q, valid_cnt_d;
   logic [3:0]      miss_cnt_q, miss_cnt_d;
   logic            frame_done_q, frame_done_d;
   logic            frame_valid_q, frame_valid_d;
   logic            locked_q, locked_d;
   // Coordinate order in all banks: tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y.
   logic [7:0][9:0] raw_q, raw_d;
   logic [7:0][9:0] shadow_q, shadow_d;
   logic [7:0][9:0] cur_q, cur_d;
   logic            vs_fall;
   logic signed [10:0] x_span, y_span;

   // One IIR step; floor rounding of >>> lets the output settle slightly below target.
   function automatic logic [9:0] iir_step(input logic [9:0] cur, input logic [9:0] raw,
                                           input logic seeded);
      logic signed [10:0] diff, step, mag;
      diff = $signed({1'b0, raw}) - $signed({1'b0, cur});
      step = diff >>> SHIFT;
      mag  = diff[10] ? -diff : diff;
      if (!seeded || (JUMP_EN && (mag > JUMP_S)))
         return raw;
      return cur + 10'(step);
   endfunction

   assign vs_fall = vs_prev_q & ~VGA_VS;
   assign x_span  = $signed({1'b0, raw_q[6]}) - $signed({1'b0, raw_q[0]});
   assign y_span  = $signed({1'b0, raw_q[5]}) - $signed({1'b0, raw_q[3]});

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      frame_ok_d    = frame_ok_q;
      seeded_d      = seeded_q;
      valid_cnt_d   = valid_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      frame_done_d  = 1'b0;
      frame_valid_d = frame_valid_q;
      locked_d      = locked_q;
      raw_d         = raw_q;
      shadow_d      = shadow_q;
      cur_d         = cur_q;
      case (state_q)
         S_IDLE: begin
            if (vs_fall) begin
               raw_d   = {bot_right_y_in, bot_right_x_in, bot_left_y_in, bot_left_x_in,
                          top_right_y_in, top_right_x_in, top_left_y_in, top_left_x_in};
               idx_d   = 3'd0;
               state_d = S_SNAP;
            end
         end
         S_SNAP: begin
            frame_ok_d = (x_span >= MIN_SPAN_S) && (y_span >= MIN_SPAN_S);
            state_d    = S_CHECK;
         end
         // The datapath is idle during CHECK, so coordinate 0 is filtered there.
         S_CHECK, S_FILTER: begin
            shadow_d[idx_q] = iir_step(cur_q[idx_q], raw_q[idx_q], seeded_q);
            idx_d           = idx_q + 3'd1;
            if ((state_q == S_CHECK) && !frame_ok_q)
               state_d = S_DONE;
            else if (idx_q == 3'd7)
               state_d = S_DONE;
            else
               state_d = S_FILTER;
         end
         S_DONE: begin
            frame_done_d  = 1'b1;
            frame_valid_d = frame_ok_q;
            state_d       = S_IDLE;
            if (frame_ok_q) begin
               cur_d      = shadow_q;
               seeded_d   = 1'b1;
               miss_cnt_d = 4'd0;
               if (valid_cnt_q < LOCK_N)
                  valid_cnt_d = valid_cnt_q + 4'd1;
               if (valid_cnt_d == LOCK_N)
                  locked_d = 1'b1;
            end else begin
               if (miss_cnt_q < MISS_N)
                  miss_cnt_d = miss_cnt_q + 4'd1;
               if (miss_cnt_d == MISS_N) begin
                  locked_d    = 1'b0;
                  valid_cnt_d = 4'd0;
                  seeded_d    = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= 3'd0;
         vs_prev_q     <= 1'b0;
         frame_ok_q    <= 1'b0;
         seeded_q      <= 1'b0;
         valid_cnt_q   <= 4'd0;
         miss_cnt_q    <= 4'd0;
         frame_done_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         cur_q         <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         vs_prev_q     <= VGA_VS;
         frame_ok_q    <= frame_ok_d;
         seeded_q      <= seeded_d;
         valid_cnt_q   <= valid_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         frame_done_q  <= frame_done_d;
         frame_valid_q <= frame_valid_d;
         locked_q      <= locked_d;
         cur_q         <= cur_d;
      end
   end

   // Snapshot and shadow banks are only read after being written in the same frame.
   always_ff @(posedge clk) begin
      raw_q    <= raw_d;
      shadow_q <= shadow_d;
   end

   assign tl_x        = cur_q[0];
   assign tl_y        = cur_q[1];
   assign tr_x        = cur_q[2];
   assign tr_y        = cur_q[3];
   assign bl_x        = cur_q[4];
   assign bl_y        = cur_q[5];
   assign br_x        = cur_q[6];
   assign br_y        = cur_q[7];
   assign frame_done  = frame_done_q;
   assign frame_valid = frame_valid_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_corner_filter.sv
// Directed bench for corner_filter: reset, latency, IIR steps, lock/loss, ignored
// falls, mid-frame reset and the jump-reseed option.
module tb_corner_filter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vga_vs = 1'b0;
   logic [9:0] tlx_i, tly_i, trx_i, try_i, blx_i, bly_i, brx_i, bry_i;
   logic [9:0] tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
   logic       frame_done, frame_valid, locked;
   int         n_checks = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   corner_filter #(
      .SHIFT(2), .MIN_SPAN(16), .LOCK_FRAMES(4), .MISS_FRAMES(8), .JUMP_THRESH(64)
   ) dut (
      .clk(clk), .reset(reset), .VGA_VS(vga_vs),
      .top_left_x_in(tlx_i), .top_left_y_in(tly_i),
      .top_right_x_in(trx_i), .top_right_y_in(try_i),
      .bot_left_x_in(blx_i), .bot_left_y_in(bly_i),
      .bot_right_x_in(brx_i), .bot_right_y_in(bry_i),
      .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
      .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y),
      .frame_done(frame_done), .frame_valid(frame_valid), .locked(locked)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic set_corners(input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h);
      tlx_i = 10'(a); tly_i = 10'(b); trx_i = 10'(c); try_i = 10'(d);
      blx_i = 10'(e); bly_i = 10'(f); brx_i = 10'(g); bry_i = 10'(h);
   endtask

   task automatic set_base();
      set_corners(100, 200, 150, 100, 140, 300, 250, 210);
   endtask

   // Returns #1 after the edge at which the fall is seen.
   task automatic vs_fall();
      @(negedge clk); vga_vs = 1'b1;
      @(negedge clk); vga_vs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_done(output int lat);
      int k;
      lat = 0;
      k = 0;
      while (lat == 0 && k < 20) begin
         k++;
         @(posedge clk); #1;
         if (frame_done) lat = k;
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (frame_done) n++;
      end
   endtask

   task automatic run_frame(input string tag, input int exp_lat);
      int lat;
      vs_fall();
      wait_done(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, int'(frame_done), 0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      set_base();
      // Reset held while VS toggles.
      nd = 0;
      repeat (6) begin
         @(negedge clk); vga_vs = ~vga_vs;
         @(posedge clk); #1;
         if (frame_done) nd++;
      end
      chk("rst_done_cnt", nd, 0);
      chk("rst_tl_x", int'(tl_x), 0);
      chk("rst_br_y", int'(br_y), 0);
      chk("rst_valid", int'(frame_valid), 0);
      chk("rst_locked", int'(locked), 0);
      @(negedge clk); reset = 1'b0;

      // First valid frame: outputs equal raw.
      run_frame("f1", 10);
      chk("f1_tl_x", int'(tl_x), 100);
      chk("f1_tl_y", int'(tl_y), 200);
      chk("f1_tr_x", int'(tr_x), 150);
      chk("f1_tr_y", int'(tr_y), 100);
      chk("f1_bl_x", int'(bl_x), 140);
      chk("f1_bl_y", int'(bl_y), 300);
      chk("f1_br_x", int'(br_x), 250);
      chk("f1_br_y", int'(br_y), 210);
      chk("f1_valid", int'(frame_valid), 1);
      chk("f1_locked", int'(locked), 0);

      // Smoothing steps from a seeded 100.
      tlx_i = 10'd101; run_frame("f2", 10);
      chk("iir_101", int'(tl_x), 100);
      chk("iir_hold_br_x", int'(br_x), 250);
      tlx_i = 10'd96;  run_frame("f3", 10);
      chk("iir_96", int'(tl_x), 99);
      chk("f3_locked", int'(locked), 0);
      tlx_i = 10'd103; run_frame("f4", 10);
      chk("iir_103", int'(tl_x), 100);
      chk("f4_locked", int'(locked), 1);
      tlx_i = 10'd140; run_frame("f5", 10);
      chk("iir_140", int'(tl_x), 110);

      // Eight narrow frames drop the lock on the eighth.
      tlx_i = 10'd110; brx_i = 10'd115;
      for (int i = 1; i <= 8; i++) begin
         run_frame("inv", 3);
         chk("inv_valid", int'(frame_valid), 0);
         chk("inv_hold_tl_x", int'(tl_x), 110);
         chk("inv_hold_br_x", int'(br_x), 250);
         chk("inv_locked", int'(locked), (i < 8) ? 1 : 0);
      end

      // Next valid frame reseeds.
      set_corners(60, 220, 170, 120, 160, 320, 270, 230);
      run_frame("reseed", 10);
      chk("reseed_tl_x", int'(tl_x), 60);
      chk("reseed_tr_y", int'(tr_y), 120);
      chk("reseed_br_y", int'(br_y), 230);
      chk("reseed_valid", int'(frame_valid), 1);
      chk("reseed_locked", int'(locked), 0);

      // Asynchronous reset clears outputs without a clock edge.
      @(negedge clk); reset = 1'b1; #1;
      chk("areset_tl_x", int'(tl_x), 0);
      @(negedge clk); reset = 1'b0;

      // A second fall during FILTER is ignored; the first snapshot wins.
      begin
         int lat;
         set_base();
         vs_fall();
         set_corners(500, 500, 500, 500, 500, 500, 500, 500);
         repeat (4) @(posedge clk);
         @(negedge clk); vga_vs = 1'b1;
         @(negedge clk); vga_vs = 1'b0;
         @(posedge clk); #1;
         wait_done(lat);
         chk("ign_lat", lat, 4);
         count_done(15, nd);
         chk("ign_no_second", nd, 0);
         chk("ign_tl_x", int'(tl_x), 100);
         chk("ign_bl_y", int'(bl_y), 300);
         chk("ign_br_x", int'(br_x), 250);
      end

      // Large jump on tl_x from a seeded 100.
      set_base(); tlx_i = 10'd300; brx_i = 10'd400;
      run_frame("jump", 10);
`ifdef CORNER_JUMP_RESEED_EN
      chk("jump_tl_x", int'(tl_x), 300);
`else
      chk("jump_tl_x", int'(tl_x), 150);
`endif
      chk("jump_tr_x", int'(tr_x), 150);

      // Reset pulse in the middle of FILTER.
      set_base();
      vs_fall();
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b1; #1;
      chk("midrst_tl_x", int'(tl_x), 0);
      chk("midrst_br_x", int'(br_x), 0);
      chk("midrst_valid", int'(frame_valid), 0);
      @(negedge clk); reset = 1'b0;
      count_done(15, nd);
      chk("midrst_no_done", nd, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
